// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data memory seen by the MEM stage.
// A request is accepted in IDLE. The responder then waits WAIT_CYC cycles and
// performs the access on entry to RESP. RESP is a one-cycle response pulse.
// Optional build macro: DMEM_OOR_ERR_EN adds o_resp_err. When it is set,
// out-of-range accesses are flagged and writes to them are suppressed.
module dmem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
`ifdef DMEM_OOR_ERR_EN
    output logic              o_resp_err,
`endif
    output logic              o_mem_stall
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_do_access;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_acc_we;
    logic [31:0]       w_acc_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oor;
    logic              w_mem_we;

    assign w_accept    = (r_state == StIdle) & i_req_valid;
    // Reset wins over entry to RESP, so an aborted access never touches memory.
    assign w_do_access = ~i_rst & (w_state_next == StResp);

    // With WAIT_CYC = 0 the access happens on the accept edge itself. At that
    // point the latched copies are not loaded yet, so take the live inputs.
    assign w_acc_addr  = (r_state == StIdle) ? i_req_addr  : r_addr;
    assign w_acc_we    = (r_state == StIdle) ? i_req_we    : r_we;
    assign w_acc_wdata = (r_state == StIdle) ? i_req_wdata : r_wdata;
    assign w_idx       = w_acc_addr[IDX_W-1:0];
    assign w_oor       = |(w_acc_addr >> IDX_W);

`ifdef DMEM_OOR_ERR_EN
    assign w_mem_we = w_do_access & w_acc_we & ~w_oor;
`else
    // Upper address bits alias modulo DEPTH in this build.
    logic w_unused_oor;
    assign w_unused_oor = w_oor;
    assign w_mem_we     = w_do_access & w_acc_we;
`endif

    // State register with synchronous reset taking priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_state_next = (WAIT_CYC != 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_req_ready  = (r_state == StIdle);
        o_resp_valid = (r_state == StResp);
    end

    assign o_mem_stall  = i_req_valid & ~o_resp_valid;
    assign o_resp_rdata = r_rdata;

    // Request latch, wait counter and response data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_req_addr;
                r_we    <= i_req_we;
                r_wdata <= i_req_wdata;
                r_cnt   <= 4'(WAIT_CYC);
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_do_access) begin
`ifdef DMEM_OOR_ERR_EN
                if (w_oor) begin
                    r_rdata <= 32'd0;
                end else begin
                    r_rdata <= w_acc_we ? w_acc_wdata : r_mem[w_idx];
                end
`else
                r_rdata <= w_acc_we ? w_acc_wdata : r_mem[w_idx];
`endif
            end
        end
    end

`ifdef DMEM_OOR_ERR_EN
    logic r_resp_err;

    // Error flag follows the response data and holds with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp_err <= 1'b0;
        end else if (w_do_access) begin
            r_resp_err <= w_oor;
        end
    end

    assign o_resp_err = r_resp_err;
`endif

    // Storage array has no reset, so its contents survive rst.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

endmodule
